// File: rtl/mem_arbiter.sv
// Shares the byte-wide unified RAM port between instruction fetch and the load/store buffer.
// Each access is a run of byte beats. Load data is assembled little-endian and extended.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_data,
   input  logic              ls_req,
   input  logic [4:0]        ls_op,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_done,
   output logic [31:0]       ls_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_a,
   output logic [7:0]        mem_dout,
   output logic              mem_wr,
   input  logic [7:0]        mem_din
);

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;
   typedef enum logic {RR_IF, RR_LS} rr_t;

   localparam logic [4:0] OP_LB  = 5'b10010;
   localparam logic [4:0] OP_LH  = 5'b10011;
   localparam logic [4:0] OP_LW  = 5'b10100;
   localparam logic [4:0] OP_LBU = 5'b10101;
   localparam logic [4:0] OP_LHU = 5'b10110;
   localparam logic [4:0] OP_SB  = 5'b10111;
   localparam logic [4:0] OP_SH  = 5'b11000;
   localparam logic [4:0] OP_SW  = 5'b11001;

   function automatic logic [2:0] beats(input logic [4:0] op);
      case (op)
         OP_LW, OP_SW:         beats = 3'd4;
         OP_LH, OP_LHU, OP_SH: beats = 3'd2;
         default:              beats = 3'd1;
      endcase
   endfunction

   state_t            state;
   rr_t               rr_last;
   logic [2:0]        cnt;
   logic [2:0]        n;
   logic [4:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:8]       wdata_q;
   logic [2:0][7:0]   lane;

   logic              is_load, is_store, ls_valid, grant_ls, grant_if;
   logic [1:0]        lane_idx;
   logic [ADDR_W-1:0] next_a;
   logic [7:0]        wbyte;
   logic [31:0]       word_rd, load_ext;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      is_load  = (ls_op >= OP_LB) && (ls_op <= OP_LHU);
      is_store = (ls_op >= OP_SB) && (ls_op <= OP_SW);
      ls_valid = ls_req && (is_load || is_store);
      // Round-robin only matters on conflict; an invalid op never competes.
      grant_ls = ls_valid && (!if_req || rr_last == RR_IF);
      grant_if = if_req && (!ls_valid || rr_last == RR_LS);

      // The byte addressed in beat k arrives RAM_LAT cycles later.
      lane_idx = cnt[1:0] - 2'(RAM_LAT);
      next_a   = addr_q + ADDR_W'(cnt) + ADDR_W'(1);

      wbyte = wdata_q[31:24];
      case (cnt[1:0])
         2'd0:    wbyte = wdata_q[15:8];
         2'd1:    wbyte = wdata_q[23:16];
         default: wbyte = wdata_q[31:24];
      endcase

      // The final byte is taken straight from mem_din in the cycle it arrives.
      word_rd = {mem_din, lane[2], lane[1], lane[0]};
      case (n)
         3'd1:    word_rd = {24'h0, mem_din};
         3'd2:    word_rd = {16'h0, mem_din, lane[0]};
         default: word_rd = {mem_din, lane[2], lane[1], lane[0]};
      endcase

      load_ext = word_rd;
      case (op_q)
         OP_LB:   load_ext = {{24{word_rd[7]}}, word_rd[7:0]};
         OP_LH:   load_ext = {{16{word_rd[15]}}, word_rd[15:0]};
         default: load_ext = word_rd;
      endcase
   end

   // NOTE: state uses non-blocking assignments only; the async reset clears mem_wr at once so an aborted store stops writing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rr_last  <= RR_IF;
         cnt      <= '0;
         n        <= '0;
         op_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         lane     <= '0;
         if_done  <= 1'b0;
         if_data  <= '0;
         ls_done  <= 1'b0;
         ls_rdata <= '0;
         busy     <= 1'b0;
         mem_a    <= '0;
         mem_dout <= '0;
         mem_wr   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (grant_ls) begin
                  rr_last <= RR_LS;
                  op_q    <= ls_op;
                  addr_q  <= ls_addr;
                  wdata_q <= ls_wdata[31:8];
                  n       <= beats(ls_op);
                  mem_a   <= ls_addr;
                  busy    <= 1'b1;
                  if (is_store) begin
                     state    <= STORE;
                     mem_wr   <= 1'b1;
                     mem_dout <= ls_wdata[7:0];
                  end else begin
                     state <= LOAD;
                  end
               end else if (grant_if) begin
                  rr_last <= RR_IF;
                  addr_q  <= if_addr;
                  n       <= 3'd4;
                  mem_a   <= if_addr;
                  busy    <= 1'b1;
                  state   <= FETCH;
               end
            end

            FETCH, LOAD: begin
               cnt <= cnt + 3'd1;
               if (cnt == n + 3'd1) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  if_done <= 1'b0;
                  ls_done <= 1'b0;
               end else if (cnt == n) begin
                  if (state == FETCH) begin
                     if_data <= word_rd;
                     if_done <= 1'b1;
                  end else begin
                     ls_rdata <= load_ext;
                     ls_done  <= 1'b1;
                  end
               end else begin
                  if (cnt != 3'd0) lane[lane_idx] <= mem_din;
                  mem_a <= (cnt + 3'd1 < n) ? next_a : '0;
               end
            end

            STORE: begin
               cnt <= cnt + 3'd1;
               if (cnt == n) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  ls_done <= 1'b0;
               end else if (cnt == n - 3'd1) begin
                  mem_wr   <= 1'b0;
                  mem_a    <= '0;
                  mem_dout <= '0;
                  ls_done  <= 1'b1;
                  ls_rdata <= '0;
               end else begin
                  mem_a    <= next_a;
                  mem_dout <= wbyte;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
